// File: rtl/can_frame_sequencer.sv
// Serialises one CAN frame (11-bit ID, 0..8 data bytes) into crc_create's
// init/id_en/data_en/bit_in controls and mirrors the stream on tx_bit.
module can_frame_sequencer #(
  parameter int BIT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [10:0] req_id,
  input  logic [3:0]  req_dlc,
  input  logic [63:0] req_data,
  input  logic        abort,
  output logic        crc_init,
  output logic        crc_id_en,
  output logic        crc_data_en,
  output logic        crc_bit,
  output logic        tx_bit,
  output logic        busy,
  output logic        done
);

  // state  | meaning
  // IDLE   | ready for a request
  // INIT   | one-cycle crc_init pulse
  // ID     | shifting 11 identifier bits
  // DATA   | shifting 8*n payload bits
  // DONE   | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ID, S_DATA, S_DONE} state_t;

  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(BIT_DIV - 1);

  state_t state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]  id_idx_q, id_idx_d;
  logic [5:0]  data_idx_q, data_idx_d;
  logic [10:0] id_q, id_d;
  logic [3:0]  n_q, n_d;
  logic [63:0] data_q, data_d;
  logic req_ready_q, req_ready_d;
  logic crc_init_q, crc_init_d;
  logic crc_id_en_q, crc_id_en_d;
  logic crc_data_en_q, crc_data_en_d;
  logic crc_bit_q, crc_bit_d;
  logic tx_bit_q, tx_bit_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic       period_end;
  logic       first_clk;
  logic [6:0] last_data;
  logic [3:0] id_sel;
  logic [5:0] data_sel;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    id_idx_d   = id_idx_q;
    data_idx_d = data_idx_q;
    id_d       = id_q;
    n_d        = n_q;
    data_d     = data_q;
    period_end = (div_q == '0);
    last_data  = {n_q, 3'b000} - 7'd1;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_INIT;
          id_d    = req_id;
          n_d     = (req_dlc > 4'd8) ? 4'd8 : req_dlc;
          data_d  = req_data;
        end
      end
      S_INIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_ID;
          div_d    = DIV_LOAD;
          id_idx_d = '0;
        end
      end
      S_ID: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (period_end) begin
          div_d = DIV_LOAD;
          if (id_idx_q == 4'd10) begin
            if (n_q == 4'd0) begin
              state_d = S_DONE;
            end else begin
              state_d    = S_DATA;
              data_idx_d = '0;
            end
          end else begin
            id_idx_d = id_idx_q + 4'd1;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      S_DATA: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (period_end) begin
          div_d = DIV_LOAD;
          if ({1'b0, data_idx_q} == last_data) begin
            state_d = S_DONE;
          end else begin
            data_idx_d = data_idx_q + 6'd1;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they land registered in step with it.
    id_sel        = 4'd10 - id_idx_d;
    data_sel      = 6'd63 - data_idx_d;
    first_clk     = (div_d == DIV_LOAD);
    req_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    crc_init_d    = (state_d == S_INIT);
    crc_id_en_d   = (state_d == S_ID) && first_clk;
    crc_data_en_d = (state_d == S_DATA) && first_clk;
    crc_bit_d     = 1'b0;
    tx_bit_d      = 1'b1;
    if (state_d == S_ID) begin
      crc_bit_d = id_d[id_sel];
      tx_bit_d  = id_d[id_sel];
    end else if (state_d == S_DATA) begin
      crc_bit_d = data_d[data_sel];
      tx_bit_d  = data_d[data_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      div_q         <= '0;
      id_idx_q      <= '0;
      data_idx_q    <= '0;
      id_q          <= '0;
      n_q           <= '0;
      data_q        <= '0;
      req_ready_q   <= 1'b1;
      crc_init_q    <= 1'b0;
      crc_id_en_q   <= 1'b0;
      crc_data_en_q <= 1'b0;
      crc_bit_q     <= 1'b0;
      tx_bit_q      <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      id_idx_q      <= id_idx_d;
      data_idx_q    <= data_idx_d;
      id_q          <= id_d;
      n_q           <= n_d;
      data_q        <= data_d;
      req_ready_q   <= req_ready_d;
      crc_init_q    <= crc_init_d;
      crc_id_en_q   <= crc_id_en_d;
      crc_data_en_q <= crc_data_en_d;
      crc_bit_q     <= crc_bit_d;
      tx_bit_q      <= tx_bit_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign crc_init    = crc_init_q;
  assign crc_id_en   = crc_id_en_q;
  assign crc_data_en = crc_data_en_q;
  assign crc_bit     = crc_bit_q;
  assign tx_bit      = tx_bit_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
